// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-stage types, instruction field positions and opcode encodings.
package cpu_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, ISSUE} fetch_state_t;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 27;
    localparam int IMM_W = 16;
    localparam int JADDR_W = 27;
    localparam logic [4:0] OP_ADD = 5'b01000;
    localparam logic [4:0] OP_BEQ = 5'b11100;
    localparam logic [4:0] OP_BNE = 5'b11101;
    localparam logic [4:0] OP_J = 5'b00000;
    localparam logic [4:0] OP_JAL = 5'b00001;
    localparam logic [4:0] OP_JR = 5'b00010;
endpackage

// File: rtl/next_pc_sel.sv
// next_pc_sel: next-PC mux (jr > jump > taken branch > sequential) with branch-target adder.
module next_pc_sel
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0]  pc_plus4,
    input  logic [IMM_W-1:0]   imm,
    input  logic [JADDR_W-1:0] jaddr,
    input  logic               branch,
    input  logic               branch_ne,
    input  logic               zero,
    input  logic               jump,
    input  logic               jr_select,
    input  logic [ADDR_W-1:2]  jr_hi,
    output logic [ADDR_W-1:0]  next_pc
);
    logic [ADDR_W-1:0] jump_tgt, br_tgt, jmask;
    logic              take;
    always_comb begin
        // jump keeps only pc_plus4 bits above the 29-bit word-aligned jump field
        jmask    = ADDR_W'({(JADDR_W+2){1'b1}});
        jump_tgt = (pc_plus4 & ~jmask) | ADDR_W'({jaddr, 2'b00});
        br_tgt   = pc_plus4 + (ADDR_W'($signed(imm)) << 2);
        take     = branch & (zero ^ branch_ne);
        next_pc  = jr_select ? {jr_hi, 2'b00} : jump ? jump_tgt : take ? br_tgt : pc_plus4;
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, imem handshake FSM, instruction register and retired-instruction counter.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic [4:0]        op_code,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    input  logic              exec_done,
    input  logic              branch,
    input  logic              branch_ne,
    input  logic              zero,
    input  logic              jump,
    input  logic              jr_select,
    input  logic [ADDR_W-1:0] jr_target,
    output logic              misalign_err,
    output logic [CNT_W-1:0]  retired
);
    fetch_state_t      state, state_next;
    logic [ADDR_W-1:0] next_pc;
    logic              load, retire;

    next_pc_sel #(.ADDR_W(ADDR_W)) u_sel (
        .pc_plus4  (pc_plus4),
        .imm       (instr[IMM_W-1:0]),
        .jaddr     (instr[JADDR_W-1:0]),
        .branch    (branch),
        .branch_ne (branch_ne),
        .zero      (zero),
        .jump      (jump),
        .jr_select (jr_select),
        .jr_hi     (jr_target[ADDR_W-1:2]),
        .next_pc   (next_pc)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_next;

    always_comb begin
        load        = (state == FETCH) && imem_ack;
        retire      = (state == ISSUE) && exec_done;
        state_next  = state == IDLE ? FETCH : load ? ISSUE : retire ? FETCH : state;
        imem_req    = state == FETCH;
        instr_valid = state == ISSUE;
        imem_addr   = pc;
        pc_plus4    = pc + ADDR_W'(4);
        op_code     = instr[OPCODE_MSB:OPCODE_LSB];
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pc           <= RESET_PC;
            instr        <= '0;
            misalign_err <= 1'b0;
            retired      <= '0;
        end else begin
            if (load) instr <= imem_rdata;
            if (retire) begin
                pc      <= next_pc;
                retired <= retired + CNT_W'(1);
                if (jr_select && (jr_target[1:0] != 2'b00)) misalign_err <= 1'b1;
            end
        end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vectors with hand-computed PCs; 4-bit retired counter to reach wrap quickly.
module tb_fetch_unit;
    import cpu_pkg::*;
    localparam int AW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          imem_req, imem_ack, instr_valid, exec_done;
    logic [AW-1:0] imem_addr, pc, pc_plus4, jr_target;
    logic [31:0]   imem_rdata, instr;
    logic [4:0]    op_code;
    logic          branch, branch_ne, zero, jump, jr_select, misalign_err;
    logic [CW-1:0] retired;
    logic [31:0]   cur_pc;
    int            n_vec = 0, n_err = 0, n_ret = 0;

    fetch_unit #(.ADDR_W(AW), .RESET_PC(32'h0), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .op_code(op_code),
        .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4), .exec_done(exec_done),
        .branch(branch), .branch_ne(branch_ne), .zero(zero), .jump(jump),
        .jr_select(jr_select), .jr_target(jr_target), .misalign_err(misalign_err),
        .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Entered in FETCH; returns one cycle into ISSUE.
    task automatic fetch(input logic [31:0] w, input int wait_n);
        check("fetch_req", 64'(imem_req), 64'd1);
        check("fetch_addr", 64'(imem_addr), 64'(cur_pc));
        for (int i = 0; i < wait_n; i++) begin
            tick;
            check("wait_req", 64'(imem_req), 64'd1);
            check("wait_addr", 64'(imem_addr), 64'(cur_pc));
        end
        imem_ack = 1'b1;
        imem_rdata = w;
        tick;
        imem_ack = 1'b0;
        check("issue_valid", 64'(instr_valid), 64'd1);
        check("issue_req", 64'(imem_req), 64'd0);
        check("issue_instr", 64'(instr), 64'(w));
    endtask

    task automatic retire(input logic jr, input logic j, input logic br, input logic bne,
                          input logic z, input logic [31:0] tgt, input logic [31:0] exp_pc);
        jr_select = jr; jump = j; branch = br; branch_ne = bne; zero = z; jr_target = tgt;
        exec_done = 1'b1;
        tick;
        {exec_done, jr_select, jump, branch, branch_ne, zero} = '0;
        jr_target = '0;
        n_ret++;
        cur_pc = exp_pc;
        check("ret_pc", 64'(pc), 64'(exp_pc));
        check("ret_addr", 64'(imem_addr), 64'(exp_pc));
        check("ret_count", 64'(retired), 64'(n_ret % 16));
    endtask

    task automatic goto_pc(input logic [31:0] a);
        fetch(32'h4000_0000, 0);
        retire(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, a, a);
    endtask

    initial begin
        {imem_ack, exec_done, branch, branch_ne, zero, jump, jr_select} = '0;
        imem_rdata = '0;
        jr_target = '0;
        cur_pc = 32'h0;
        tick;
        tick;
        check("rst_req", 64'(imem_req), 64'd0);
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_pc", 64'(pc), 64'd0);
        check("rst_instr", 64'(instr), 64'd0);
        check("rst_retired", 64'(retired), 64'd0);
        check("rst_misalign", 64'(misalign_err), 64'd0);
        tick;
        rst_n = 1'b1;
        check("idle_req", 64'(imem_req), 64'd0);
        tick;
        // sequential add
        fetch(32'h4000_0000, 0);
        check("add_opcode", 64'(op_code), 64'(OP_ADD));
        check("add_pc4", 64'(pc_plus4), 64'h4);
        retire(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h4);
        // beq taken / not taken, bne taken; imm = -2 from pc 0x10
        goto_pc(32'h10);
        fetch(32'hE000_FFFE, 0);
        check("beq_opcode", 64'(op_code), 64'(OP_BEQ));
        retire(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0C);
        goto_pc(32'h10);
        fetch(32'hE000_FFFE, 0);
        retire(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h14);
        goto_pc(32'h10);
        fetch(32'hE000_FFFE, 0);
        retire(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0C);
        // jump beats a taken branch (branch target would be 0x124)
        goto_pc(32'h20);
        fetch(32'h0000_0040, 0);
        check("jal_pc4", 64'(pc_plus4), 64'h24);
        retire(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h100);
        check("pre_misalign", 64'(misalign_err), 64'd0);
        // jr beats jump, misaligned target
        fetch(32'h0000_0040, 0);
        retire(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0203, 32'h200);
        check("misalign_set", 64'(misalign_err), 64'd1);
        // spurious exec_done in FETCH, slow memory, spurious ack in ISSUE
        exec_done = 1'b1; jr_select = 1'b1; jr_target = 32'h80;
        tick;
        exec_done = 1'b0; jr_select = 1'b0; jr_target = '0;
        check("spur_done_pc", 64'(pc), 64'h200);
        check("spur_done_cnt", 64'(retired), 64'(n_ret % 16));
        fetch(32'h4000_0000, 4);
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick;
        imem_ack = 1'b0;
        check("spur_ack_instr", 64'(instr), 64'h4000_0000);
        check("spur_ack_valid", 64'(instr_valid), 64'd1);
        check("spur_ack_pc", 64'(pc), 64'h200);
        retire(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h204);
        check("misalign_sticky", 64'(misalign_err), 64'd1);
        // pc wrap
        goto_pc(32'hFFFF_FFFC);
        fetch(32'h4000_0000, 0);
        check("wrap_pc4", 64'(pc_plus4), 64'h0);
        retire(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        // retired counter wrap
        while (n_ret % 16 != 0) begin
            fetch(32'h4000_0000, 0);
            retire(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, cur_pc + 32'h4);
        end
        check("ret_wrap", 64'(retired), 64'd0);
        check("misalign_hold", 64'(misalign_err), 64'd1);
        // async reset mid-fetch, late ack ignored
        check("pre_rst_req", 64'(imem_req), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", 64'(imem_req), 64'd0);
        check("mid_rst_pc", 64'(pc), 64'd0);
        check("mid_rst_misalign", 64'(misalign_err), 64'd0);
        imem_ack = 1'b1;
        imem_rdata = 32'h1234_5678;
        tick;
        rst_n = 1'b1;
        tick;
        imem_ack = 1'b0;
        check("late_ack_instr", 64'(instr), 64'd0);
        check("late_ack_valid", 64'(instr_valid), 64'd0);
        check("late_ack_req", 64'(imem_req), 64'd1);
        n_ret = 0;
        cur_pc = 32'h0;
        fetch(32'h4000_0000, 0);
        retire(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h4);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
